counter_tick_controller: RTL and testbench
==========================================

Name: counter_tick_controller

Overview:
Sequencer that drives the enable input of the 0-9 auto bidirectional counter. It turns a slow board clock into a one-cycle enable pulse train at a selectable rate. It provides run/pause control and single-step control from two raw push-buttons, each synchronised and debounced on chip. It sits between the board buttons/switches and the counter's enable port. It does not touch count value or direction.

Parameters:
DEB_CYCLES, 4, consecutive stable synchronised samples required before a debounced button level changes (>=2)
DIV_0, 8, enable period in clki cycles for speed_sel=0 (>=2)
DIV_1, 16, enable period for speed_sel=1 (>=2)
DIV_2, 32, enable period for speed_sel=2 (>=2)
DIV_3, 64, enable period for speed_sel=3 (>=2)
PRE_W, 16, prescaler width; must hold max(DIV_n)-1

Ports:
clki  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clock clki
btn_run  in  1  raw run/pause button, asynchronous, active-high
btn_step  in  1  raw single-step button, asynchronous, active-high
speed_sel  in  2  rate select, quasi-static
enable_o  out  1  one-cycle enable pulse to counter, registered
running  out  1  1 = RUNNING state, registered

Behaviour:
- Reset (async, any time, including mid-debounce or mid-period):
  - state=PAUSED; enable_o=0; running=0.
  - Prescaler=0; synchroniser flops=0; debounced levels=0; debounce counters=0.
  - speed_q=0 (see below).
- Input conditioning:
  - Each button passes through a 2-flop synchroniser, then a debouncer.
  - Debouncer counter: increments each edge where the sync output differs from the debounced level; clears on any edge where they match.
  - When the counter equals DEB_CYCLES-1 and the levels still differ, the debounced level flips and the counter clears.
  - Press pulse = debounced level high AND its previous-cycle value low. It lasts exactly one cycle per press. Releases generate nothing.
  - Latency: raw rise sampled at edge 1 -> debounced level high after edge DEB_CYCLES+2 -> press pulse valid during the following cycle.
  - Glitches shorter than DEB_CYCLES sync samples are rejected.
- FSM (2 states):
  - PAUSED: run press -> RUNNING (prescaler<=0). Step press -> enable_o<=1 for one cycle; state stays PAUSED.
  - RUNNING: run press -> PAUSED (prescaler<=0, enable_o<=0 on that edge). Step press is ignored.
  - Run press and step press in the same cycle: run wins, step is dropped.
  - running = (state==RUNNING), updated on the same edge as the state.
- Prescaler (RUNNING only; held at 0 in PAUSED):
  - period = DIV_n selected by speed_q.
  - Each edge: if prescaler==period-1, then prescaler<=0 and enable_o<=1; else prescaler<=prescaler+1 and enable_o<=0.
  - Entering RUNNING at edge N: enable_o first high after edge N+period, then every period cycles, each pulse exactly 1 cycle.
- Speed change:
  - speed_q is a register sampling speed_sel every edge.
  - On an edge where speed_sel != speed_q: prescaler<=0 and no pulse is issued on that edge, even at terminal count. The new period applies from that edge.
  - In PAUSED a speed change has no visible effect.
- enable_o is never high for 2 consecutive cycles: period>=2, and a step cannot follow within 1 cycle because press pulses are single-cycle and debounced.

Test Plan:
- Reset mid-run: RUNNING with speed_sel=0, assert reset for 3 cycles at prescaler=5 -> enable_o=0 and running=0 immediately (async); after release, no pulses for 100 cycles.
- Run press: DEB_CYCLES=4, speed_sel=0, hold btn_run high for 20 cycles -> running rises after edge 7; enable_o pulses after edges 15, 23, 31 (period 8), each 1 cycle wide. Counter model sees 0,1,2,3.
- Step while paused: btn_step held 10 cycles -> exactly one enable_o pulse, after edge 7. Step press while RUNNING -> pulse spacing unchanged.
- Bounce rejection: btn_run toggling every 2 cycles for 30 cycles, then low -> running stays 0, enable_o stays 0. Same toggling then held high 10 cycles -> exactly one transition to RUNNING.
- Speed change: RUNNING at speed_sel=0, change to 2 when prescaler=6 -> no pulse at the expected terminal edge; next pulse 32 cycles after the change edge, then every 32.
- Simultaneous presses: btn_run and btn_step rise on the same cycle while PAUSED -> RUNNING entered; no step pulse; first enable_o exactly period cycles after entry.

Source files
------------

// File: rtl/counter_tick_controller.sv
// Enable-pulse sequencer for the 0-9 counter: debounced run/step buttons,
// a PAUSED/RUNNING FSM and a rate-selectable prescaler.

module counter_tick_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clki,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clki or posedge reset) begin
    if (reset) begin
      r_sync    <= 2'b00;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync    <= {r_sync[0], i_btn};
      r_level_d <= r_level;
      if (r_sync[1] != r_level) begin
        if (r_cnt == CNT_MAX) begin
          r_level <= r_sync[1];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // One cycle per debounced rising level; releases produce nothing.
  assign o_press = r_level & ~r_level_d;
endmodule

// State table:
//   ST_PAUSED  | prescaler held at 0; step press gives a single enable pulse
//   ST_RUNNING | prescaler free-runs, enable pulse on each terminal count
module counter_tick_controller #(
  parameter int DEB_CYCLES = 4,
  parameter int DIV_0      = 8,
  parameter int DIV_1      = 16,
  parameter int DIV_2      = 32,
  parameter int DIV_3      = 64,
  parameter int PRE_W      = 16
) (
  input  logic       clki,
  input  logic       reset,
  input  logic       btn_run,
  input  logic       btn_step,
  input  logic [1:0] speed_sel,
  output logic       enable_o,
  output logic       running
);
  typedef enum logic {ST_PAUSED = 1'b0, ST_RUNNING = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PRE_W-1:0]  r_pre;
  logic [PRE_W-1:0]  w_pre_nxt;
  logic [PRE_W-1:0]  w_period_m1;
  logic [1:0]        r_speed_q;
  logic              r_enable;
  logic              r_running;
  logic              w_enable_nxt;
  logic              w_run_press;
  logic              w_step_press;
  logic              w_speed_chg;

  counter_tick_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
    .clki    (clki),
    .reset   (reset),
    .i_btn   (btn_run),
    .o_press (w_run_press)
  );

  counter_tick_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
    .clki    (clki),
    .reset   (reset),
    .i_btn   (btn_step),
    .o_press (w_step_press)
  );

  assign w_speed_chg = (speed_sel != r_speed_q);

  always_comb begin
    w_period_m1 = PRE_W'(DIV_0 - 1);
    case (r_speed_q)
      2'd0: w_period_m1 = PRE_W'(DIV_0 - 1);
      2'd1: w_period_m1 = PRE_W'(DIV_1 - 1);
      2'd2: w_period_m1 = PRE_W'(DIV_2 - 1);
      2'd3: w_period_m1 = PRE_W'(DIV_3 - 1);
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pre_nxt    = '0;
    w_enable_nxt = 1'b0;
    case (r_state)
      ST_PAUSED: begin
        if (w_run_press) begin
          w_state_nxt = ST_RUNNING;
        end else if (w_step_press) begin
          w_enable_nxt = 1'b1;
        end
      end
      ST_RUNNING: begin
        // Run press beats a speed change; a speed change restarts the period.
        if (w_run_press) begin
          w_state_nxt = ST_PAUSED;
        end else if (w_speed_chg) begin
          w_pre_nxt = '0;
        end else if (r_pre == w_period_m1) begin
          w_enable_nxt = 1'b1;
        end else begin
          w_pre_nxt = r_pre + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clki or posedge reset) begin
    if (reset) begin
      r_state   <= ST_PAUSED;
      r_pre     <= '0;
      r_enable  <= 1'b0;
      r_running <= 1'b0;
      r_speed_q <= 2'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_pre     <= w_pre_nxt;
      r_enable  <= w_enable_nxt;
      r_running <= (w_state_nxt == ST_RUNNING);
      r_speed_q <= speed_sel;
    end
  end

  assign enable_o = r_enable;
  assign running  = r_running;
endmodule

// File: tb/tb_counter_tick_controller.sv
// Bench for counter_tick_controller: vector table, directed corner sequences,
// and random button/speed stimulus against an event-scheduling reference model.

module tb_counter_tick_controller;
  localparam int DEB = 4;
  localparam int D0  = 8;
  localparam int D1  = 16;
  localparam int D2  = 32;
  localparam int D3  = 64;

  logic       clki = 1'b0;
  logic       reset = 1'b1;
  logic       btn_run = 1'b0;
  logic       btn_step = 1'b0;
  logic [1:0] speed_sel = 2'd0;
  logic       enable_o;
  logic       running;

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    bit         run;
    bit         step;
    logic [1:0] spd;
    bit         exp_en;
    bit         exp_running;
  } vec_t;

  always #5 clki = ~clki;

  counter_tick_controller #(
    .DEB_CYCLES(DEB), .DIV_0(D0), .DIV_1(D1), .DIV_2(D2), .DIV_3(D3), .PRE_W(16)
  ) dut (
    .clki      (clki),
    .reset     (reset),
    .btn_run   (btn_run),
    .btn_step  (btn_step),
    .speed_sel (speed_sel),
    .enable_o  (enable_o),
    .running   (running)
  );

  function automatic int per(input logic [1:0] s);
    case (s)
      2'd0:    return D0;
      2'd1:    return D1;
      2'd2:    return D2;
      default: return D3;
    endcase
  endfunction

  // Debounced level flips once the last DEB synchronised samples all disagree with it.
  function automatic bit all_differ(input int q[$], input bit lev);
    for (int i = 2; i < DEB + 2; i++)
      if (q[i] == int'(lev)) return 1'b0;
    return 1'b1;
  endfunction

  int   mq_run[$];
  int   mq_step[$];
  bit   mlev_run, mlev_step, mpress_run, mpress_step;
  bit   mrun, men;
  logic [1:0] mspq;
  int   mt, mnext;

  always @(posedge clki or posedge reset) begin
    if (reset) begin
      mq_run.delete();
      mq_step.delete();
      for (int i = 0; i < DEB + 2; i++) begin
        mq_run.push_back(0);
        mq_step.push_back(0);
      end
      mlev_run = 0; mlev_step = 0; mpress_run = 0; mpress_step = 0;
      mrun = 0; men = 0; mspq = 2'd0; mt = 0; mnext = 0;
    end else begin
      mt++;
      men = 0;
      if (!mrun) begin
        if (mpress_run) begin
          mrun  = 1;
          mnext = mt + per(speed_sel);
        end else if (mpress_step) begin
          men = 1;
        end
      end else begin
        if (mpress_run) mrun = 0;
        else if (speed_sel != mspq) mnext = mt + per(speed_sel);
        else if (mt == mnext) begin
          men   = 1;
          mnext = mt + per(mspq);
        end
      end
      mspq = speed_sel;
      mq_run.push_front(int'(btn_run));
      void'(mq_run.pop_back());
      mq_step.push_front(int'(btn_step));
      void'(mq_step.pop_back());
      mpress_run = 0;
      if (all_differ(mq_run, mlev_run)) begin
        mlev_run   = ~mlev_run;
        mpress_run = mlev_run;
      end
      mpress_step = 0;
      if (all_differ(mq_step, mlev_step)) begin
        mlev_step   = ~mlev_step;
        mpress_step = mlev_step;
      end
    end
  end

  always @(negedge clki) begin
    nchk++;
    if (enable_o !== men || running !== mrun) begin
      nerr++;
      $display("FAIL model t=%0t: enable_o=%b running=%b, expected %b %b",
               $time, enable_o, running, men, mrun);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1; btn_run = 1'b0; btn_step = 1'b0; speed_sel = 2'd0;
    repeat (3) @(negedge clki);
    reset = 1'b0;
  endtask

  task automatic wait_en(input string nm);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clki);
      found = enable_o;
    end
    chk(nm, int'(found), 1);
  endtask

  task automatic press_run();
    btn_run = 1'b1;
    repeat (10) @(negedge clki);
    btn_run = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vec[32];
    int n, first, rises, prev, offgrid, rcnt, cval;
    for (int e = 1; e <= 32; e++)
      vec[e-1] = '{run: (e <= 20), step: 1'b0, spd: 2'd0,
                   exp_en: (e == 15 || e == 23 || e == 31), exp_running: (e >= 7)};

    @(negedge clki);
    chk("reset_enable", int'(enable_o), 0);
    chk("reset_running", int'(running), 0);
    repeat (2) @(negedge clki);
    reset = 1'b0;

    // Run press held 20 cycles, period 8.
    cval = 0;
    for (int i = 0; i < 32; i++) begin
      btn_run = vec[i].run; btn_step = vec[i].step; speed_sel = vec[i].spd;
      @(negedge clki);
      chk($sformatf("tbl_en_e%0d", i + 1), int'(enable_o), int'(vec[i].exp_en));
      chk($sformatf("tbl_run_e%0d", i + 1), int'(running), int'(vec[i].exp_running));
      if (enable_o) cval = (cval + 1) % 10;
    end
    chk("counter_value", cval, 3);

    // Step while paused.
    do_reset();
    n = 0; first = 0;
    for (int e = 1; e <= 30; e++) begin
      btn_step = (e <= 10);
      @(negedge clki);
      if (enable_o) begin n++; if (first == 0) first = e; end
    end
    chk("step_pulses", n, 1);
    chk("step_edge", first, 7);
    chk("step_running", int'(running), 0);

    // Step while running leaves spacing untouched.
    do_reset();
    n = 0; offgrid = 0;
    for (int e = 1; e <= 70; e++) begin
      btn_run  = (e <= 10);
      btn_step = (e >= 20 && e < 30);
      @(negedge clki);
      if (enable_o) begin n++; if ((e - 7) % 8 != 0) offgrid++; end
    end
    chk("runstep_pulses", n, 7);
    chk("runstep_offgrid", offgrid, 0);

    // Simultaneous run and step presses.
    do_reset();
    n = 0; first = 0; rises = 0;
    for (int e = 1; e <= 20; e++) begin
      btn_run = (e <= 10); btn_step = (e <= 10);
      @(negedge clki);
      if (running && rises == 0) rises = e;
      if (enable_o) begin n++; if (first == 0) first = e; end
    end
    chk("sim_running_edge", rises, 7);
    chk("sim_pulses", n, 1);
    chk("sim_first_pulse", first, 15);

    // Bounce rejection, then bounce followed by a clean hold.
    do_reset();
    rises = 0; n = 0; prev = 0;
    for (int e = 1; e <= 60; e++) begin
      btn_run = (e <= 30) ? (((e - 1) / 2) % 2 == 0) : 1'b0;
      @(negedge clki);
      if (running && !prev) rises++;
      prev = running;
      if (enable_o) n++;
    end
    chk("bounce_rises", rises, 0);
    chk("bounce_pulses", n, 0);
    rises = 0; prev = 0;
    for (int e = 1; e <= 70; e++) begin
      btn_run = (e <= 30) ? (((e - 1) / 2) % 2 == 0) : (e <= 40);
      @(negedge clki);
      if (running && !prev) rises++;
      prev = running;
    end
    chk("bounce_hold_rises", rises, 1);

    // Speed change at prescaler=6.
    do_reset();
    press_run();
    wait_en("spd_wait_first");
    repeat (6) @(negedge clki);
    speed_sel = 2'd2;
    n = 0; first = -1;
    for (int k = 0; k <= 64; k++) begin
      @(negedge clki);
      if (enable_o) begin n++; if (first < 0) first = k; end
    end
    chk("spd_first_pulse", first, 32);
    chk("spd_pulses", n, 2);

    // Asynchronous reset mid-run.
    do_reset();
    press_run();
    wait_en("rst_wait_first");
    repeat (5) @(negedge clki);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_running", int'(running), 0);
    chk("rst_async_enable", int'(enable_o), 0);
    repeat (3) @(negedge clki);
    reset = 1'b0;
    n = 0; rcnt = 0;
    repeat (100) begin
      @(negedge clki);
      if (enable_o) n++;
      if (running) rcnt++;
    end
    chk("rst_after_pulses", n, 0);
    chk("rst_after_running", rcnt, 0);
    press_run();
    wait_en("rst_wait_pulse");
    #2 reset = 1'b1;
    #1;
    chk("rst_during_pulse", int'(enable_o), 0);
    repeat (3) @(negedge clki);
    reset = 1'b0;

    // Random stimulus against the reference model.
    do_reset();
    for (int seg = 0; seg < 400; seg++) begin
      btn_run  = ($urandom_range(0, 4) == 0);
      btn_step = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) speed_sel = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 12)) @(negedge clki);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
